alu_result_tracer: RTL

- Downstream capture stage for the processor's 32-bit ALU result bus; sits beside main_module in simulation and on-board debug.
- Samples ALU results each clock and tags each with a free-running cycle stamp.
- Buffers entries in a circular FIFO and drains them over a valid/ready read port, so results can be checked or logged without halting the core.

---
 rtl/alu_result_tracer.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_result_tracer.sv
// Capture stage for the 32-bit ALU result bus: tags each captured result with a
// free-running cycle stamp and buffers it in a first-word fall-through FIFO.
module alu_result_tracer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STAMP_W     = 16,
  parameter int unsigned CHANGE_ONLY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              alu_result,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic [STAMP_W-1:0]       rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 32 + STAMP_W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [31:0]        last_q, last_d;
  logic               last_vld_q, last_vld_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [EW-1:0]      head;

  logic full_w, req, pop, push, drop;

  always_comb begin
    full_w = (count_q == FULL_CNT);
    req    = capture_en && ((CHANGE_ONLY == 0) || !last_vld_q || (alu_result != last_q));
    pop    = (count_q != '0) && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push   = req && (!full_w || pop);
    drop   = req && full_w && !pop;
  end

  always_comb begin
    stamp_d    = stamp_q + STAMP_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
      last_vld_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      if (push) begin
        last_d     = alu_result;
        last_vld_d = 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != 8'hff) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      stamp_q    <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      stamp_q    <= stamp_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  // Storage carries no reset; visibility is governed entirely by count and pointers.
  always_ff @(posedge clk) begin
    if (reset && push && !clear) mem_q[wr_ptr_q] <= {alu_result, stamp_q};
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    rd_valid   = (count_q != '0);
    rd_data    = rd_valid ? head[EW-1:STAMP_W] : '0;
    rd_stamp   = rd_valid ? head[STAMP_W-1:0] : '0;
    count      = count_q;
    full       = full_w;
    overflow   = overflow_q;
    drop_count = drop_q;
  end

endmodule
